// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte producers, the shared UART tx arbiter and its serializer.
// The arbiter connects through the slave modport; producer/serializer models use master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 10
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_grant;
  logic [DATA_W-1:0]         o_tx_data;
  logic                      o_tx_enable;
  logic                      i_tx_done;
  logic                      o_busy;
  logic                      o_timeout;

  modport slave (
    input  i_req, i_req_data, i_tx_done,
    output o_grant, o_tx_data, o_tx_enable, o_busy, o_timeout
  );

  modport master (
    output i_req, i_req_data, i_tx_done,
    input  o_grant, o_tx_data, o_tx_enable, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx serializer between NUM_REQ producers,
// with a fixed-length enable window, tx_done edge completion and a watchdog abort.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 10,
  parameter int EN_CYCLES = 10417,
  parameter int TIMEOUT   = 1200000
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int EN_W  = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [EN_W-1:0] EN_LAST = EN_W'(EN_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, sel, rr_idx;
  logic [EN_W-1:0]    en_cnt_q, en_cnt_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               en_q, en_d;
  logic               timeout_q, timeout_d;
  logic               done_q;
  logic               any_req, done_rise, en_last, wd_last;

  assign any_req   = |bus.i_req;
  assign done_rise = bus.i_tx_done & ~done_q;
  assign en_last   = (en_cnt_q == EN_LAST);
  assign wd_last   = (wd_cnt_q == WD_LAST);

  // Scan downward so the candidate closest after ptr is the last one written and wins.
  always_comb begin
    sel    = ptr_q;
    rr_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rr_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (bus.i_req[rr_idx]) sel = rr_idx;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      en_cnt_q  <= '0;
      wd_cnt_q  <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      en_cnt_q  <= en_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
      done_q    <= bus.i_tx_done;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (wd_last) state_d = IDLE;
               else if (en_last) state_d = WAIT;
      WAIT:    if (done_rise || wd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done edge beats a same-cycle watchdog expiry, so the timeout flag is set only without it.
  always_comb begin
    ptr_d     = ptr_q;
    en_cnt_d  = en_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    grant_d   = '0;
    data_d    = data_q;
    en_d      = en_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d    = sel;
          grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
          data_d   = bus.i_req_data[sel*DATA_W +: DATA_W];
          en_d     = 1'b1;
          en_cnt_d = '0;
          wd_cnt_d = '0;
        end
      end
      ISSUE: begin
        if (en_last) en_d = 1'b0;
        else         en_cnt_d = en_cnt_q + 1'b1;
        if (wd_last) begin
          en_d      = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (wd_last) begin
          if (!done_rise) timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_tx_data   = data_q;
  assign bus.o_tx_enable = en_q;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_timeout   = timeout_q;
endmodule
